// File: rtl/ltc2315_spi_responder.sv
// LTC2315-12 slave-side emulator: drives SDO against an external SPI master so the
// capture path can be looped back without a converter. SCK/CS_n are oversampled on clk.
module ltc2315_spi_responder #(
  parameter logic [11:0] RAMP_STEP  = 12'd1,
  parameter logic [11:0] PATTERN    = 12'hA5A,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs_n,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [1:0]  mode,
  input  logic [11:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CntW = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StWaitCs} state_e;

  // Synchroniser and edge-detect flops
  logic sck_meta_q, sck_sync_q, sck_dly_q;
  logic cs_meta_q, cs_sync_q, cs_dly_q;
  logic sck_fall, cs_fall, cs_rise;

  state_e          state_q, state_d;
  logic [15:0]     shreg_q, shreg_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            sdo_oe_q, sdo_oe_d;
  logic [11:0]     hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [11:0]     last_q, last_d;
  logic [11:0]     ramp_q, ramp_d;
  logic            alt_q, alt_d;
  logic [1:0]      frame_mode_q, frame_mode_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic            underrun_q, underrun_d;

  logic [11:0] sample;
  logic        starve;
  logic        start;

  // Two-flop synchronisers plus a delay flop for edge detection; CS idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_dly_q  <= 1'b0;
      cs_meta_q  <= 1'b1;
      cs_sync_q  <= 1'b1;
      cs_dly_q   <= 1'b1;
    end else begin
      sck_meta_q <= sck;
      sck_sync_q <= sck_meta_q;
      sck_dly_q  <= sck_sync_q;
      cs_meta_q  <= cs_n;
      cs_sync_q  <= cs_meta_q;
      cs_dly_q   <= cs_sync_q;
    end
  end

  assign sck_fall = sck_dly_q & ~sck_sync_q;
  assign cs_fall  = cs_dly_q & ~cs_sync_q;
  assign cs_rise  = ~cs_dly_q & cs_sync_q;
  assign start    = (state_q == StIdle) && cs_fall;

  // Select the sample for a frame starting now; an empty holding register in
  // external mode falls back to s_data if it is being offered, else replays.
  always_comb begin
    sample = last_q;
    starve = 1'b0;
    unique case (mode)
      2'd0: begin
        if (hold_full_q) begin
          sample = hold_q;
        end else if (s_valid) begin
          sample = s_data;
        end else begin
          starve = 1'b1;
        end
      end
      2'd1:    sample = ramp_q;
      2'd2:    sample = PATTERN;
      default: sample = alt_q ? 12'hFFF : 12'h000;
    endcase
  end

  // Holding register: emptied by a mode-0 frame start, which also bypasses a
  // same-cycle offer so that s_ready never drops for it.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (start && (mode == 2'd0)) begin
      hold_full_d = 1'b0;
    end else if (s_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = s_data;
    end
  end

  // Frame FSM next-state and registered outputs
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    sdo_oe_d     = sdo_oe_q;
    last_d       = last_q;
    ramp_d       = ramp_q;
    alt_d        = alt_q;
    frame_mode_d = frame_mode_q;
    frame_cnt_d  = frame_cnt_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    underrun_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        sdo_oe_d = 1'b0;
        if (cs_fall) begin
          shreg_d      = {1'b0, sample, 3'b000};
          last_d       = sample;
          bit_cnt_d    = '0;
          frame_mode_d = mode;
          underrun_d   = starve;
          sdo_oe_d     = 1'b1;
          state_d      = StShift;
        end
      end
      StShift: begin
        if (sck_fall && (bit_cnt_q == LastBit)) begin
          // Completion wins over a coincident CS rise.
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (frame_mode_q == 2'd1) ramp_d = ramp_q + RAMP_STEP;
          if (frame_mode_q == 2'd3) alt_d = ~alt_q;
          shreg_d  = '0;
          sdo_oe_d = ~cs_rise;
          state_d  = cs_rise ? StIdle : StWaitCs;
        end else if (cs_rise) begin
          abort_d  = 1'b1;
          shreg_d  = '0;
          sdo_oe_d = 1'b0;
          state_d  = StIdle;
        end else if (sck_fall) begin
          shreg_d   = {shreg_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      StWaitCs: begin
        shreg_d  = '0;
        sdo_oe_d = 1'b1;
        if (cs_rise) begin
          sdo_oe_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        shreg_d  = '0;
        sdo_oe_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      sdo_oe_q     <= 1'b0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_q       <= '0;
      ramp_q       <= '0;
      alt_q        <= 1'b0;
      frame_mode_q <= 2'd0;
      frame_cnt_q  <= '0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      sdo_oe_q     <= sdo_oe_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      last_q       <= last_d;
      ramp_q       <= ramp_d;
      alt_q        <= alt_d;
      frame_mode_q <= frame_mode_d;
      frame_cnt_q  <= frame_cnt_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      underrun_q   <= underrun_d;
    end
  end

  assign sdo         = shreg_q[15];
  assign sdo_oe      = sdo_oe_q;
  assign s_ready     = ~hold_full_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign underrun    = underrun_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/ltc2315_spi_responder.md
Name: ltc2315_spi_responder

Overview:
- Slave-side emulator of the LTC2315-12 serial ADC interface; the counterpart of the SPI master reader.
- Drives SDO in response to master SCK/CS_n, so the capture path, FIFOs and Ethernet stream can be looped back on the board without a real converter.
- Sample source per frame, selected by `mode`:
  - external sample with valid/ready handshake;
  - internal ramp;
  - fixed pattern;
  - alternating full-scale.
- SCK and CS_n are treated as asynchronous and oversampled on `clk`.

Parameters:
- RAMP_STEP, 1, ramp increment per frame (12-bit, wraps modulo 4096).
- PATTERN, 12'hA5A, constant sample for mode 2.
- FRAME_BITS, 16, SCK falling edges per complete frame (1 lead zero + 12 data + 3 trailing zeros).

Ports:
- clk  in  1  system clock; must be ≥ 4× SCK frequency.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  master serial clock, asynchronous.
- cs_n  in  1  master chip select, active low, asynchronous.
- sdo  out  1  serial data to master.
- sdo_oe  out  1  output enable for top-level tristate; 1 = drive.
- mode  in  2  sample source: 0 external, 1 ramp, 2 PATTERN, 3 alternate 12'h000/12'hFFF.
- s_data  in  12  external sample.
- s_valid  in  1  external sample valid.
- s_ready  out  1  holding register empty.
- frame_done  out  1  one-cycle pulse, full frame sent.
- frame_abort  out  1  one-cycle pulse, CS_n rose early.
- underrun  out  1  one-cycle pulse, mode 0 frame started with empty holding register.
- frame_cnt  out  16  completed frames, wraps.

Behaviour:
- Reset values:
  - outputs: sdo=0, sdo_oe=0, s_ready=1, pulses=0, frame_cnt=0;
  - internal: ramp=0, last_sample=0, alt toggle=0, state=IDLE.
- Synchronisers and edge detection:
  - sck and cs_n each pass 2 flops, plus a 3rd flop for edge detect.
  - cs_fall/cs_rise/sck_fall are single-cycle strobes, 3 clk after the pin edge.
- Holding register:
  - loads s_data when s_valid && s_ready; s_ready drops the next cycle.
  - consumed (s_ready=1 next cycle) at frame start in mode 0.
- FSM states: IDLE, SHIFT, WAIT_CS.
- IDLE:
  - sdo_oe=0.
  - On cs_fall:
    - select the sample per mode and load shift register {1'b0, sample, 3'b000};
    - mode 0 with holding register empty → reuse last_sample and pulse underrun;
    - last_sample <= sample; bit_cnt=0;
    - sdo_oe=1; sdo = lead zero; go to SHIFT.
- SHIFT:
  - each sck_fall: shift left, sdo = next bit, bit_cnt+1.
  - D11 appears after the 1st falling edge and D0 after the 12th, so the master samples on rising edges.
  - When bit_cnt reaches FRAME_BITS-1 on an sck_fall:
    - pulse frame_done;
    - frame_cnt+1;
    - ramp += RAMP_STEP (mode 1 only); alt toggles (mode 3 only);
    - go to WAIT_CS with sdo=0.
  - cs_rise in SHIFT before completion:
    - sdo_oe=0, pulse frame_abort, IDLE;
    - no counter or ramp update;
    - external sample already consumed and not replayed.
- WAIT_CS:
  - sdo=0, sdo_oe=1; extra SCK edges are ignored.
  - cs_rise → sdo_oe=0, IDLE.
- Simultaneous events:
  - cs_rise in the same cycle as the final sck_fall: frame_done wins, then immediately IDLE.
  - cs_fall in the same cycle as s_valid with the register empty: the new s_data is used directly, s_ready stays 1.
- A mode change takes effect at the next cs_fall only.
- Async reset mid-frame: sdo_oe=0 immediately; all state restarts in IDLE.

Test Plan:
- Reset/tristate: assert rst_n=0 mid-frame → sdo_oe=0, sdo=0 within 0 clk; after release with cs_n high → s_ready=1, frame_cnt=0.
- Mode 2, clk=100 MHz, SCK=12.5 MHz, one full 16-bit frame → master captures 0_101001011010_000, frame_done pulses once, frame_cnt=1.
- Mode 1, RAMP_STEP=1, 4100 frames → captured values 0,1,…,4095,0,1,2,3 (wrap), no aborts.
- Mode 0: s_data=12'h123 accepted, then two frames → first frame 12'h123 with no underrun; second frame 12'h123 repeated with underrun pulsed once and s_ready=1.
- Abort: cs_n rises after 6 SCK falls in mode 1 → frame_abort pulses, sdo_oe=0, frame_cnt unchanged, next frame carries the same ramp value.
- Mode 3 plus extra SCK: 3 frames of 18 SCK falls each → 12'h000, 12'hFFF, 12'h000; edges 17–18 output 0; frame_cnt=3.
